// File: rtl/instr_prefetch.sv
// Instruction prefetch queue.
// Fetches sequential words from a combinational ROM into a small circular
// queue and presents the oldest entry to decode. Redirect flushes the queue
// and restarts fetching from the new target on the following edge.
module instr_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   output logic [7:0]  rom_address,
   input  logic [31:0] rom_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [4:0]  level
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc    [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [4:0]    count;
   logic          push;
   logic          pop;

   // Handshake decode: redirect suppresses both push and pop; a pop frees a
   // slot in the same cycle so a full queue can still accept a new word.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      pop  = (count != '0) && instr_ready && !redirect;
      push = enable && !redirect && ((count < 5'(DEPTH)) || pop);
   end

   assign rom_address = fetch_pc[9:2];
   assign instr_valid = (count != '0);
   assign instr       = q_instr[head];
   assign instr_pc    = q_pc[head];
   assign level       = count;

   // Queue storage, pointers, occupancy and fetch address.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         // Clearing storage makes the head entry read back as zero after reset.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i]    <= '0;
         end
      end else if (redirect) begin
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            q_instr[tail] <= rom_data;
            q_pc[tail]    <= fetch_pc;
            tail          <= tail + 1'b1;
            fetch_pc      <= fetch_pc + 32'd4;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_instr_prefetch;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [7:0]  rom_address;
   logic [31:0] rom_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [4:0]  level;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   // ROM word k holds value k.
   assign rom_data = {24'h0, rom_address};

   instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .rom_address (rom_address),
      .rom_data    (rom_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .level       (level)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of (pc, word) pairs plus the next fetch address.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc;
   bit          live = 0;

   always @(posedge clock) begin
      bit do_pop, do_push;
      if (reset) begin
         mq.delete();
         mpc  = RESET_PC;
         live = 1;
      end else if (redirect) begin
         mq.delete();
         mpc = {redirect_pc[31:2], 2'b00};
      end else begin
         do_pop  = (mq.size() > 0) && instr_ready;
         do_push = enable && ((mq.size() < DEPTH) || do_pop);
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back('{pc: mpc, w: {24'h0, mpc[9:2]}});
            mpc = mpc + 32'd4;
         end
      end
   end

   // Compare process: every cycle after the first reset.
   always @(negedge clock) begin
      if (live) begin
         chk("instr_valid", {31'h0, instr_valid}, {31'h0, (mq.size() != 0)});
         chk("level", {27'h0, level}, mq.size());
         chk("rom_address", {24'h0, rom_address}, {24'h0, mpc[9:2]});
         if (mq.size() != 0) begin
            chk("instr", instr, mq[0].w);
            chk("instr_pc", instr_pc, mq[0].pc);
         end
      end
   end

   task automatic cyc();
      @(negedge clock);
      #1;
   endtask

   task automatic drive(input logic rst, input logic en, input logic rdy,
                        input logic rd, input logic [31:0] rpc);
      reset       = rst;
      enable      = en;
      instr_ready = rdy;
      redirect    = rd;
      redirect_pc = rpc;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1, 0, 0, 0, 0);
      cyc(); cyc();

      // Reset state
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_level", {27'h0, level}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_rom_address", {24'h0, rom_address}, 32'h0);

      // Streaming: pc 0,4,8 with words 0,1,2
      drive(0, 1, 1, 0, 0);
      for (int unsigned k = 0; k < 3; k++) begin
         cyc();
         chk("stream_valid", {31'h0, instr_valid}, 32'h1);
         chk("stream_pc", instr_pc, 4 * k);
         chk("stream_instr", instr, k);
      end

      // Backpressure: fill to DEPTH, fetch address frozen
      drive(1, 0, 0, 0, 0);
      cyc();
      drive(0, 1, 0, 0, 0);
      for (int unsigned k = 0; k < 10; k++) cyc();
      chk("full_level", {27'h0, level}, 32'd4);
      chk("full_rom_address", {24'h0, rom_address}, 32'h04);
      chk("full_head_pc", instr_pc, 32'h0);
      drive(0, 1, 1, 0, 0);
      for (int unsigned k = 1; k < 8; k++) begin
         cyc();
         chk("drain_pc", instr_pc, 4 * k);
         chk("drain_level", {27'h0, level}, 32'd4);
      end

      // Redirect with 3 entries queued
      drive(1, 0, 0, 0, 0);
      cyc();
      drive(0, 1, 0, 0, 0);
      cyc(); cyc(); cyc();
      chk("pre_redirect_level", {27'h0, level}, 32'd3);
      drive(0, 1, 0, 1, 32'h0000_0043);
      cyc();
      chk("redir_valid", {31'h0, instr_valid}, 32'h0);
      chk("redir_rom_address", {24'h0, rom_address}, 32'h10);
      drive(0, 1, 1, 0, 0);
      cyc();
      chk("redir_target_pc", instr_pc, 32'h40);
      chk("redir_target_instr", instr, 32'h10);

      // enable=0: drain, fetch address holds, then resume
      drive(0, 0, 1, 0, 0);
      for (int unsigned k = 0; k < 5; k++) cyc();
      chk("hold_level", {27'h0, level}, 32'h0);
      chk("hold_rom_address", {24'h0, rom_address}, 32'h11);
      drive(0, 1, 1, 0, 0);
      cyc();
      chk("resume_pc", instr_pc, 32'h44);

      // ROM address wrap at 256 words, then reset mid-stream
      drive(0, 1, 1, 1, 32'h0000_03FC);
      cyc();
      chk("wrap_rom_address_ff", {24'h0, rom_address}, 32'hFF);
      drive(0, 1, 1, 0, 0);
      cyc();
      chk("wrap_pc_3fc", instr_pc, 32'h3FC);
      chk("wrap_rom_address_00", {24'h0, rom_address}, 32'h00);
      cyc();
      chk("wrap_pc_400", instr_pc, 32'h400);
      chk("wrap_instr_400", instr, 32'h0);
      drive(1, 1, 1, 0, 0);
      cyc();
      chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
      chk("midrst_instr_pc", instr_pc, 32'h0);
      drive(0, 1, 1, 0, 0);
      cyc();
      chk("midrst_restart_pc", instr_pc, RESET_PC);

      // Randomized traffic, checked by the compare process each cycle
      for (int unsigned k = 0; k < 3000; k++) begin
         logic [31:0] r;
         logic [31:0] rpc;
         r = $urandom;
         case (r[9:8])
            2'd0:    rpc = 32'hFFFF_FFF0 | {30'h0, r[1:0]};
            2'd1:    rpc = {22'h0, r[19:10]};
            default: rpc = $urandom;
         endcase
         drive(r[15:10] == 6'd0,
               r[3:2] != 2'd0,
               (r[24] ? 1'b1 : r[5]),
               r[30:27] == 4'd0,
               rpc);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
